// File: rtl/led_flash_ctrl.sv
// PMOD pulse LED counter: synchronize, debounce, strobe, then IDLE/COUNT/FLASH/CLEAR sequencing.
// Optional build macro LEDFLASH_GRAY_EN makes o_LED show the Gray code of the count.
module led_flash_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FLASH_DIV       = 8,
    parameter int LED_W           = 4
) (
    input  logic             i_SCLK,
    input  logic             i_RESET_SYSB,
    input  logic             i_PMOD1_P1,
    input  logic             i_MODE,
    input  logic             i_CLEAR,
    output logic [LED_W-1:0] o_LED,
    output logic             o_PULSE_STB,
    output logic             o_OVF
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(FLASH_DIV);

    typedef enum logic [1:0] {IDLE, COUNT, FLASH, CLEAR} state_t;

    state_t           state;
    logic             sync1, sync2;
    logic             db_level, db_prev;
    logic [CNT_W-1:0] db_cnt;
    logic [LED_W-1:0] count;
    logic [DIV_W-1:0] div;
    logic             phase;

    function automatic logic [LED_W-1:0] disp(input logic [LED_W-1:0] v);
`ifdef LEDFLASH_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Input path: 2-flop synchronizer, debounce counter, registered rising-edge strobe
    always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
        if (!i_RESET_SYSB) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            db_level    <= 1'b0;
            db_prev     <= 1'b0;
            db_cnt      <= '0;
            o_PULSE_STB <= 1'b0;
        end else begin
            sync1 <= i_PMOD1_P1;
            sync2 <= sync1;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            db_prev     <= db_level;
            o_PULSE_STB <= db_level && !db_prev && (state != CLEAR);
        end
    end

    // Mode FSM; o_LED is derived from the registered state, so it trails it by one cycle
    always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
        if (!i_RESET_SYSB) begin
            state <= IDLE;
            count <= '0;
            div   <= '0;
            phase <= 1'b0;
            o_OVF <= 1'b0;
            o_LED <= '0;
        end else begin
            unique case (state)
                COUNT:   o_LED <= disp(count);
                FLASH:   o_LED <= phase ? disp(count) : '0;
                default: o_LED <= '0;
            endcase

            if (i_CLEAR) begin
                state <= CLEAR;
                count <= '0;
                div   <= '0;
                phase <= 1'b0;
                o_OVF <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_MODE) begin
                            state <= FLASH;
                        end else if (o_PULSE_STB) begin
                            state <= COUNT;
                            count <= count + 1'b1;
                        end
                    end
                    COUNT: begin
                        if (o_PULSE_STB) begin
                            count <= count + 1'b1;
                            if (count == '1) o_OVF <= 1'b1;
                        end
                        if (i_MODE) state <= FLASH;
                    end
                    FLASH: begin
                        if (!i_MODE) begin
                            state <= COUNT;
                            div   <= '0;
                            phase <= 1'b0;
                        end else if (div == DIV_W'(FLASH_DIV - 1)) begin
                            div   <= '0;
                            phase <= ~phase;
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                    CLEAR: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
